cache_way_select: RTL

// Way-select stage of the 4-way set-associative cache, directly upstream of the 4:1 line-data mux.
// - Accepts a lookup (index, tag) and reads the external synchronous tag RAM.
// - Compares the tag against all 4 ways and produces the one-hot way select that drives the mux select input.
// - On a miss, picks the victim way: the lowest invalid way first, otherwise the tree pseudo-LRU way.
// - Holds the per-set pseudo-LRU state.

---
 rtl/cache_way_select.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cache_way_select.sv
// Way-select stage of a 4-way set-associative cache: tag compare, hit/victim
// one-hot select for the line-data mux, and per-set tree pseudo-LRU state.
module cache_way_select #(
  parameter int unsigned TAG_BITS   = 20,
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [INDEX_BITS-1:0] i_req_index,
  input  logic [TAG_BITS-1:0]   i_req_tag,
  output logic                  o_tag_rd_en,
  output logic [INDEX_BITS-1:0] o_tag_rd_index,
  input  logic [4*TAG_BITS-1:0] i_way_tags,
  input  logic [3:0]            i_way_valid,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [3:0]            o_sel,
  output logic                  o_hit,
  output logic                  o_multi_hit,
  output logic [INDEX_BITS-1:0] o_index,
  output logic [TAG_BITS-1:0]   o_tag
);

  localparam int unsigned WAYS     = 4;
  localparam int unsigned NUM_SETS = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [INDEX_BITS-1:0] idx_q;
  logic [TAG_BITS-1:0]   tag_q;
  logic [2:0]            plru_q [NUM_SETS];

  logic [WAYS-1:0] hit_vec_c;
  logic [WAYS-1:0] sel_c;
  logic            multi_c;
  logic [2:0]      plru_rd_c;
  logic [2:0]      plru_next_c;
  logic            plru_we_c;

  // Priority pick of the lowest set bit; zero in, zero out.
  function automatic logic [3:0] lowest_one(input logic [3:0] v);
    logic [3:0] r;
    casez (v)
      4'b???1: r = 4'b0001;
      4'b??10: r = 4'b0010;
      4'b?100: r = 4'b0100;
      4'b1000: r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Tree walk {b2,b1,b0}: b0 picks the pair, b1/b2 pick within the pair.
  function automatic logic [3:0] plru_victim(input logic [2:0] p);
    logic [3:0] r;
    if (!p[0]) r = p[1] ? 4'b0010 : 4'b0001;
    else       r = p[2] ? 4'b1000 : 4'b0100;
    return r;
  endfunction

  // Point the tree away from the way just used.
  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [3:0] sel);
    logic [2:0] r;
    r = p;
    case (sel)
      4'b0001: begin r[0] = 1'b1; r[1] = 1'b1; end
      4'b0010: begin r[0] = 1'b1; r[1] = 1'b0; end
      4'b0100: begin r[0] = 1'b0; r[2] = 1'b1; end
      4'b1000: begin r[0] = 1'b0; r[2] = 1'b0; end
      default: r = p;
    endcase
    return r;
  endfunction

  assign o_req_ready    = (state_q == IDLE);
  assign o_tag_rd_en    = i_req_valid & o_req_ready;
  assign o_tag_rd_index = i_req_index;

  for (genvar g = 0; g < WAYS; g++) begin : g_cmp
    assign hit_vec_c[g] = i_way_valid[g] & (i_way_tags[g*TAG_BITS +: TAG_BITS] == tag_q);
  end

  assign plru_rd_c = plru_q[idx_q];

  // Hit way first, then lowest invalid way, then the PLRU victim.
  always_comb begin
    sel_c   = 4'b0000;
    multi_c = 1'b0;
    if (hit_vec_c != 4'b0000) begin
      sel_c   = lowest_one(hit_vec_c);
      multi_c = ((hit_vec_c & (hit_vec_c - 4'd1)) != 4'b0000);
    end else if (i_way_valid != 4'b1111) begin
      sel_c = lowest_one(~i_way_valid);
    end else begin
      sel_c = plru_victim(plru_rd_c);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_req_valid) state_d = LOOKUP;
      LOOKUP:  state_d = RESP;
      RESP:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Request capture and registered result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q       <= '0;
      tag_q       <= '0;
      o_valid     <= 1'b0;
      o_sel       <= 4'b0000;
      o_hit       <= 1'b0;
      o_multi_hit <= 1'b0;
      o_index     <= '0;
      o_tag       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            idx_q <= i_req_index;
            tag_q <= i_req_tag;
          end
        end
        LOOKUP: begin
          o_valid     <= 1'b1;
          o_sel       <= sel_c;
          o_hit       <= (hit_vec_c != 4'b0000);
          o_multi_hit <= multi_c;
          o_index     <= idx_q;
          o_tag       <= tag_q;
        end
        RESP: begin
          if (i_ready) o_valid <= 1'b0;
        end
        default: o_valid <= 1'b0;
      endcase
    end
  end

  // PLRU touch only on the result handshake, for hits and misses alike.
  assign plru_we_c   = (state_q == RESP) & o_valid & i_ready;
  assign plru_next_c = plru_touch(plru_rd_c, o_sel);

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        plru_q[s] <= 3'b000;
      end else if (plru_we_c && (idx_q == INDEX_BITS'(s))) begin
        plru_q[s] <= plru_next_c;
      end
    end
  end

endmodule
